payment_settle: RTL and testbench

Coin-payment and settlement stage placed directly downstream of the commodity chooser. Takes the chooser's binary item price and one-hot item code, accumulates 1/5/10-yuan coin pulses, and issues a one-cycle dispense pulse once the paid amount covers the price. It computes the change and returns the full payment on cancel or inactivity timeout. Paid and change amounts are presented as two-digit BCD for the display stage.

---
 rtl/payment_settle.sv | 145 ++++++++++++++
 tb/tb_payment_settle.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/payment_settle.sv
// Coin payment and settlement stage: accumulates 1/5/10 coins against a latched
// price, pulses dispense when covered, and returns change or a full refund.
module payment_settle #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] price,
    input  logic [3:0] goods_num,
    input  logic       coin1,
    input  logic       coin5,
    input  logic       coin10,
    input  logic       cancel,
    output logic [7:0] paid_bcd,
    output logic [7:0] change_bcd,
    output logic       dispense,
    output logic [3:0] dispense_num,
    output logic       refund,
    output logic       coin_reject,
    output logic       busy
);

    localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned AMT_W    = 7;
    localparam int unsigned SUM_W    = 8;
    localparam int unsigned COIN_W   = 5;
    localparam int unsigned MAX_PAID = 99;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAY    = 2'd1,
        VEND   = 2'd2,
        RETURN = 2'd3
    } state_t;

    state_t             state;
    logic [AMT_W-1:0]   paid_q;
    logic [AMT_W-1:0]   change_q;
    logic [3:0]         price_q;
    logic [3:0]         item_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               armed;

    logic [COIN_W-1:0]  coin_val_c;
    logic [SUM_W-1:0]   paid_sum_c;
    logic               any_coin_c;
    logic               coin_take_c;

    // Coin value for this cycle and whether PAY can absorb it without exceeding 99
    assign coin_val_c  = COIN_W'(coin1) + (coin5 ? COIN_W'(5) : COIN_W'(0))
                       + (coin10 ? COIN_W'(10) : COIN_W'(0));
    assign any_coin_c  = coin1 | coin5 | coin10;
    assign paid_sum_c  = SUM_W'(paid_q) + SUM_W'(coin_val_c);
    assign coin_take_c = (state == PAY) && any_coin_c && !cancel
                       && (paid_sum_c <= SUM_W'(MAX_PAID));

    function automatic logic [7:0] to_bcd(input logic [AMT_W-1:0] v);
        logic [AMT_W-1:0] tens;
        logic [AMT_W-1:0] ones;
        tens = v / AMT_W'(10);
        ones = v % AMT_W'(10);
        return {4'(tens), 4'(ones)};
    endfunction

    assign paid_bcd   = to_bcd(paid_q);
    assign change_bcd = to_bcd(change_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            paid_q       <= '0;
            change_q     <= '0;
            price_q      <= '0;
            item_q       <= '0;
            tmo_cnt      <= '0;
            armed        <= 1'b1;
            dispense     <= 1'b0;
            dispense_num <= '0;
            refund       <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            dispense     <= 1'b0;
            dispense_num <= '0;
            refund       <= 1'b0;
            coin_reject  <= any_coin_c && !coin_take_c;
            // Re-arm only on an explicit deselect so a held price cannot re-trigger
            if (price == 4'd0) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (price != 4'd0 && armed) begin
                        state    <= PAY;
                        busy     <= 1'b1;
                        price_q  <= price;
                        item_q   <= goods_num;
                        paid_q   <= '0;
                        change_q <= '0;
                        tmo_cnt  <= '0;
                        armed    <= 1'b0;
                    end
                end
                PAY: begin
                    if (coin_take_c) begin
                        paid_q <= AMT_W'(paid_sum_c);
                    end
                    // A coin accepted this cycle restarts the idle window instead of timing out
                    if (cancel) begin
                        state    <= RETURN;
                        change_q <= paid_q;
                        refund   <= 1'b1;
                    end else if (paid_q >= AMT_W'(price_q)) begin
                        state        <= VEND;
                        dispense     <= 1'b1;
                        dispense_num <= item_q;
                    end else if (coin_take_c) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state    <= RETURN;
                        change_q <= paid_q;
                        refund   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                VEND: begin
                    state    <= RETURN;
                    change_q <= paid_q - AMT_W'(price_q);
                    refund   <= 1'b1;
                end
                RETURN: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    paid_q <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_payment_settle.sv
// Self-checking bench for payment_settle: directed scenarios plus randomized
// traffic compared against a timestamp-based transaction model.
module tb_payment_settle;

    localparam int TMO = 8;
    localparam int BIG = 32'h7fff_ffff;

    logic       clk;
    logic       rst;
    logic [3:0] price;
    logic [3:0] goods_num;
    logic       coin1;
    logic       coin5;
    logic       coin10;
    logic       cancel;
    logic [7:0] paid_bcd;
    logic [7:0] change_bcd;
    logic       dispense;
    logic [3:0] dispense_num;
    logic       refund;
    logic       coin_reject;
    logic       busy;

    int checks;
    int failures;
    int cyc;

    // Transaction model state: open flag, amounts, and scheduled event cycles
    bit m_paying;
    bit m_armed;
    bit m_reject;
    int m_paid;
    int m_price;
    int m_item;
    int m_last;
    int m_disp_at;
    int m_refund_at;
    int m_idle_at;
    int m_chg_val;
    int m_chg_at;

    payment_settle #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .price        (price),
        .goods_num    (goods_num),
        .coin1        (coin1),
        .coin5        (coin5),
        .coin10       (coin10),
        .cancel       (cancel),
        .paid_bcd     (paid_bcd),
        .change_bcd   (change_bcd),
        .dispense     (dispense),
        .dispense_num (dispense_num),
        .refund       (refund),
        .coin_reject  (coin_reject),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_paying    = 1'b0;
        m_armed     = 1'b1;
        m_reject    = 1'b0;
        m_paid      = 0;
        m_price     = 0;
        m_item      = 0;
        m_last      = 0;
        m_disp_at   = -1;
        m_refund_at = -1;
        m_idle_at   = 0;
        m_chg_val   = 0;
        m_chg_at    = BIG;
    endtask

    task automatic close_refund(input int t, input int amount);
        m_paying    = 1'b0;
        m_refund_at = t + 1;
        m_idle_at   = t + 2;
        m_chg_val   = amount;
        m_chg_at    = t + 1;
    endtask

    // Advance the model over cycle t using the inputs currently driven
    task automatic model_step(input int t);
        int  val;
        int  old;
        bit  take;
        val  = int'(coin1) + 5 * int'(coin5) + 10 * int'(coin10);
        take = 1'b0;
        if (m_paying) begin
            old  = m_paid;
            take = (val != 0) && !cancel && (old + val <= 99);
            if (cancel) begin
                close_refund(t, old);
            end else if (old >= m_price) begin
                m_paying    = 1'b0;
                m_disp_at   = t + 1;
                m_refund_at = t + 2;
                m_idle_at   = t + 3;
                m_chg_val   = old + (take ? val : 0) - m_price;
                m_chg_at    = t + 2;
            end else if (!take && (t - m_last == TMO)) begin
                close_refund(t, old);
            end
            if (take) begin
                m_paid = old + val;
                m_last = t;
            end
        end else if (t >= m_idle_at && price != 4'd0 && m_armed) begin
            m_paying  = 1'b1;
            m_paid    = 0;
            m_price   = int'(price);
            m_item    = int'(goods_num);
            m_last    = t;
            m_chg_val = 0;
            m_chg_at  = BIG;
            m_armed   = 1'b0;
        end
        if (price == 4'd0) m_armed = 1'b1;
        m_reject = (val != 0) && !take;
    endtask

    function automatic logic [23:0] model_outs(input int c);
        logic [7:0] p;
        logic [7:0] ch;
        logic       d;
        logic [3:0] n;
        logic       r;
        logic       b;
        b  = m_paying || (c < m_idle_at);
        p  = b ? to_bcd(m_paid) : 8'h00;
        ch = (c >= m_chg_at) ? to_bcd(m_chg_val) : 8'h00;
        d  = (c == m_disp_at);
        n  = d ? 4'(m_item) : 4'h0;
        r  = (c == m_refund_at);
        return {p, ch, d, n, r, m_reject, b};
    endfunction

    // One clock: model consumes this cycle's inputs, then outputs settle #1 after the edge
    task automatic tick();
        model_step(cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        coin1  = 1'b0;
        coin5  = 1'b0;
        coin10 = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        price = 4'd0;
        goods_num = 4'd0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({paid_bcd, change_bcd, dispense, dispense_num, refund, coin_reject, busy} !== 24'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=000000",
                     {paid_bcd, change_bcd, dispense, dispense_num, refund, coin_reject, busy});
        end
        rst = 1'b0;
        cyc = 0;
        model_reset();
    endtask

    task automatic test_price7_two_coins();
        price = 4'd0; tick();
        price = 4'd7; goods_num = 4'b0100; tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL p7_busy got=%b exp=1", busy); end
        coin5 = 1'b1; tick(); coin5 = 1'b0;
        checks++;
        if (paid_bcd !== 8'h05) begin failures++; $display("FAIL p7_paid5 got=%h exp=05", paid_bcd); end
        coin5 = 1'b1; tick(); coin5 = 1'b0;
        checks++;
        if (paid_bcd !== 8'h10) begin failures++; $display("FAIL p7_paid10 got=%h exp=10", paid_bcd); end
        tick();
        checks++;
        if ({dispense, dispense_num} !== 5'b1_0100) begin
            failures++; $display("FAIL p7_dispense got=%b/%b exp=1/0100", dispense, dispense_num);
        end
        tick();
        checks++;
        if ({refund, dispense, change_bcd} !== {1'b1, 1'b0, 8'h03}) begin
            failures++; $display("FAIL p7_refund got=%b/%b/%h exp=1/0/03", refund, dispense, change_bcd);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL p7_idle got=%b exp=0", busy); end
    endtask

    task automatic test_simultaneous_coins();
        price = 4'd0; tick();
        price = 4'd2; goods_num = 4'b0001; tick();
        coin1 = 1'b1; coin5 = 1'b1; coin10 = 1'b1; tick(); clear_inputs();
        checks++;
        if (paid_bcd !== 8'h16) begin failures++; $display("FAIL sim_paid got=%h exp=16", paid_bcd); end
        tick();
        checks++;
        if ({dispense, dispense_num} !== 5'b1_0001) begin
            failures++; $display("FAIL sim_dispense got=%b/%b exp=1/0001", dispense, dispense_num);
        end
        tick();
        checks++;
        if ({refund, change_bcd} !== {1'b1, 8'h14}) begin
            failures++; $display("FAIL sim_change got=%b/%h exp=1/14", refund, change_bcd);
        end
        tick();
    endtask

    task automatic test_cancel();
        price = 4'd0; tick();
        price = 4'd10; goods_num = 4'b1000; tick();
        coin5 = 1'b1; tick(); coin5 = 1'b0;
        checks++;
        if (paid_bcd !== 8'h05) begin failures++; $display("FAIL cancel_paid got=%h exp=05", paid_bcd); end
        cancel = 1'b1; tick(); cancel = 1'b0;
        checks++;
        if ({refund, dispense, change_bcd} !== {1'b1, 1'b0, 8'h05}) begin
            failures++; $display("FAIL cancel_refund got=%b/%b/%h exp=1/0/05", refund, dispense, change_bcd);
        end
        tick();
        checks++;
        if ({busy, dispense} !== 2'b00) begin failures++; $display("FAIL cancel_idle got=%b%b exp=00", busy, dispense); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0) begin failures++; $display("FAIL held_price_no_restart i=%0d got=%b exp=0", i, busy); end
        end
    endtask

    task automatic test_coin_reject();
        price = 4'd0;
        coin10 = 1'b1; tick(); coin10 = 1'b0;
        checks++;
        if ({coin_reject, paid_bcd} !== {1'b1, 8'h00}) begin
            failures++; $display("FAIL idle_reject got=%b/%h exp=1/00", coin_reject, paid_bcd);
        end
        tick();
        checks++;
        if (coin_reject !== 1'b0) begin failures++; $display("FAIL reject_clear got=%b exp=0", coin_reject); end
        price = 4'd10; goods_num = 4'b0010; tick();
        coin5 = 1'b1; cancel = 1'b1; tick(); clear_inputs();
        checks++;
        if ({coin_reject, refund, change_bcd} !== {1'b1, 1'b1, 8'h00}) begin
            failures++; $display("FAIL cancel_coin_reject got=%b/%b/%h exp=1/1/00", coin_reject, refund, change_bcd);
        end
        tick();
    endtask

    task automatic test_timeout();
        price = 4'd0; tick();
        price = 4'd10; goods_num = 4'b0100; tick();
        coin1 = 1'b1; tick(); coin1 = 1'b0;
        for (int k = 2; k <= TMO; k++) begin
            tick();
            checks++;
            if ({refund, busy} !== 2'b01) begin
                failures++; $display("FAIL timeout_early k=%0d got=%b%b exp=01", k, refund, busy);
            end
        end
        tick();
        checks++;
        if ({refund, dispense, change_bcd} !== {1'b1, 1'b0, 8'h01}) begin
            failures++; $display("FAIL timeout_refund got=%b/%b/%h exp=1/0/01", refund, dispense, change_bcd);
        end
        tick();
    endtask

    task automatic test_reset_mid_pay();
        price = 4'd0; tick();
        price = 4'd7; goods_num = 4'b0010; tick();
        coin5 = 1'b1; tick(); coin5 = 1'b0;
        checks++;
        if (paid_bcd !== 8'h05) begin failures++; $display("FAIL midrst_paid got=%h exp=05", paid_bcd); end
        price = 4'd0;
        rst = 1'b1;
        #1;
        checks++;
        if ({paid_bcd, change_bcd, dispense, dispense_num, refund, coin_reject, busy} !== 24'h0) begin
            failures++;
            $display("FAIL midrst_async got=%h exp=000000",
                     {paid_bcd, change_bcd, dispense, dispense_num, refund, coin_reject, busy});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({dispense, refund, busy, paid_bcd} !== 11'h0) begin
                failures++; $display("FAIL midrst_quiet i=%0d got=%b%b%b/%h exp=000/00", i, dispense, refund, busy, paid_bcd);
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] exp_v;
        logic [23:0] got_v;
        int          rate;
        for (int i = 0; i < 3000; i++) begin
            rate = ((i / 200) % 2 == 1) ? 20 : 5;
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 4))
                    0:       price = 4'd0;
                    1:       price = 4'd2;
                    2:       price = 4'd5;
                    3:       price = 4'd7;
                    default: price = 4'd10;
                endcase
                goods_num = 4'(1 << $urandom_range(0, 3));
            end
            coin1  = ($urandom_range(0, rate - 1) == 0);
            coin5  = ($urandom_range(0, rate - 1) == 0);
            coin10 = ($urandom_range(0, rate - 1) == 0);
            cancel = ($urandom_range(0, 40) == 0);
            tick();
            exp_v = model_outs(cyc);
            got_v = {paid_bcd, change_bcd, dispense, dispense_num, refund, coin_reject, busy};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h (paid,chg,disp,num,ref,rej,busy)", cyc, got_v, exp_v);
            end
        end
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        model_reset();
        test_reset();
        test_price7_two_coins();
        test_simultaneous_coins();
        test_cancel();
        test_coin_reject();
        test_timeout();
        test_reset_mid_pay();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
